// File: rtl/i2s_dac_tx_pkg.sv
// i2s_tx_pkg
// Shared widths, timing constants and types for the stereo I2S DAC transmitter.
// Holds the sample/slot geometry, the stereo-pair type carried by the FIFO,
// the transmitter start-up state enum and the frame packing helper.
package i2s_tx_pkg;

  localparam int SAMPLE_W  = 24;
  localparam int SLOT_W    = 32;
  localparam int FRAME_CYC = 4 * SLOT_W;
  localparam int PAD_W     = SLOT_W - SAMPLE_W - 1;
  localparam int PH_W      = $clog2(FRAME_CYC);
  localparam int FRAME_W   = 2 * SLOT_W;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_pair_t;

  // ST_WARMUP covers the first frame after reset, whose closing boundary
  // emits silence without flagging an underrun.
  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } tx_state_e;

  // Standard I2S layout: one idle bit after each word-select edge, then the
  // sample MSB first, then zero padding up to the end of the slot.
  function automatic logic [FRAME_W-1:0] pack_frame(input stereo_pair_t p);
    return {1'b0, p.left, {PAD_W{1'b0}}, 1'b0, p.right, {PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/i2s_dac_tx_if.sv
// i2s_dac_tx_if
// Sample write bus between the pitch/sample producer and the I2S transmitter.
//   write            producer -> tx   push strobe
//   writedata_left   producer -> tx   left sample, two's complement
//   writedata_right  producer -> tx   right sample, two's complement
//   write_ready      tx -> producer   FIFO has room for another pair
interface i2s_dac_tx_if;
  import i2s_tx_pkg::*;

  logic                write;
  logic [SAMPLE_W-1:0] writedata_left;
  logic [SAMPLE_W-1:0] writedata_right;
  logic                write_ready;

  modport master (
    output write,
    output writedata_left,
    output writedata_right,
    input  write_ready
  );

  modport slave (
    input  write,
    input  writedata_left,
    input  writedata_right,
    output write_ready
  );

endinterface

// File: rtl/i2s_dac_tx_stereo_fifo2.sv
// stereo_fifo2
// Two-entry FIFO of stereo pairs that decouples the producer strobe from the
// fixed frame rate.
//   clk, reset  clock and asynchronous active-high reset
//   push        store push_data (caller guarantees count < 2)
//   push_data   pair to store
//   pop         retire the head pair (caller guarantees count > 0 or push)
//   head        oldest pair; when empty it forwards push_data so a pair
//               written on the very cycle of a pop can be consumed at once
//   count       number of stored pairs, 0..2
module stereo_fifo2
  import i2s_tx_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  stereo_pair_t push_data,
  input  logic         pop,
  output stereo_pair_t head,
  output logic [1:0]   count
);

  stereo_pair_t mem_q [2];
  stereo_pair_t mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  // Pointer and occupancy update. A push and pop on an empty FIFO advance
  // both pointers together, so the pair passes straight through and the
  // occupancy stays zero.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = (count_q == 2'd0) ? push_data : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx
// Stereo I2S transmitter. Generates bit clock and word select from slow_clk,
// buffers up to two stereo pairs and serialises one pair per 128-cycle frame.
//   slow_clk     block clock
//   reset        asynchronous, active-high
//   bus          sample write bus (slave side)
//   dac_bclk     bit clock, slow_clk / 2
//   dac_lrck     word select, 0 = left slot, 1 = right slot
//   dac_data     serial data, MSB first
//   frame_start  one-cycle pulse while the phase counter is 0
//   underrun     sticky: a frame boundary found no pair to send
//   overflow     sticky: a write arrived while the FIFO was full
module i2s_dac_tx
  import i2s_tx_pkg::*;
(
  input  logic        slow_clk,
  input  logic        reset,
  i2s_dac_tx_if.slave bus,
  output logic        dac_bclk,
  output logic        dac_lrck,
  output logic        dac_data,
  output logic        frame_start,
  output logic        underrun,
  output logic        overflow
);

  logic [PH_W-1:0]    ph_q, ph_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  tx_state_e          state_q, state_d;
  logic               frame_start_q, frame_start_d;
  logic               underrun_q, underrun_d;
  logic               overflow_q, overflow_d;

  logic               write_ready;
  logic               push;
  logic               pop;
  logic               avail;
  logic               boundary;
  logic [1:0]         fifo_count;
  stereo_pair_t       push_pair;
  stereo_pair_t       head_pair;

  assign write_ready     = (fifo_count != 2'd2);
  assign bus.write_ready = write_ready;
  assign push            = bus.write && write_ready;
  assign push_pair       = {bus.writedata_left, bus.writedata_right};
  assign boundary        = (ph_q == PH_W'(FRAME_CYC - 1));
  // A pair written on the boundary cycle itself counts as available.
  assign avail           = (fifo_count != 2'd0) || push;
  assign pop             = boundary && (state_q == ST_RUN) && avail;

  stereo_fifo2 u_fifo (
    .clk       (slow_clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_pair),
    .pop       (pop),
    .head      (head_pair),
    .count     (fifo_count)
  );

  // Start-up tracking: leave warm-up at the first frame boundary.
  always_comb begin
    state_d = state_q;
    if (boundary) begin
      state_d = ST_RUN;
    end
  end

  // Phase, shift register and flag next-state. The frame load at the
  // 127 -> 0 wrap takes priority over the shift that would otherwise happen
  // on that odd -> even step.
  always_comb begin
    ph_d          = ph_q + PH_W'(1);
    shift_d       = shift_q;
    frame_start_d = boundary;
    underrun_d    = underrun_q;
    overflow_d    = overflow_q | (bus.write && !write_ready);
    if (boundary) begin
      if (pop) begin
        shift_d = pack_frame(head_pair);
      end else begin
        shift_d = '0;
        if (state_q == ST_RUN) begin
          underrun_d = 1'b1;
        end
      end
    end else if (ph_q[0]) begin
      shift_d = shift_q << 1;
    end
  end

  // State registers, all cleared asynchronously so a mid-frame reset
  // silences the outputs at once.
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      ph_q          <= '0;
      shift_q       <= '0;
      state_q       <= ST_WARMUP;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      ph_q          <= ph_d;
      shift_q       <= shift_d;
      state_q       <= state_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      overflow_q    <= overflow_d;
    end
  end

  assign dac_bclk    = ph_q[0];
  assign dac_lrck    = ph_q[PH_W-1];
  assign dac_data    = shift_q[FRAME_W-1];
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign overflow    = overflow_q;

endmodule
